// File: rtl/clk_reconfig_ctrl_pkg.sv
// rtl/clk_reconfig_ctrl_pkg.sv - shared types and register map for the clocking-wizard reconfiguration master
package clk_gen_pkg;

  typedef enum logic [2:0] {
    IDLE, WR, WR_RESP, RD, RD_RESP, GAP, FIN
  } state_t;

  typedef enum logic {DIV, CFG} step_t;

  localparam logic [10:0] DEF_DIV_ADDR  = 11'h208;
  localparam logic [10:0] DEF_CFG_ADDR  = 11'h25C;
  localparam logic [10:0] DEF_STAT_ADDR = 11'h004;
  localparam logic [31:0] DEF_CFG_LOAD  = 32'h0000_0003;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/clk_reconfig_ctrl_if.sv
// rtl/clk_reconfig_ctrl_if.sv - AXI-Lite bus between the reconfiguration master and the wizard DRP slave
interface clk_reconfig_ctrl_if #(
  parameter int ADDR_W = 11
) ();
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/clk_reconfig_ctrl.sv
// rtl/clk_reconfig_ctrl.sv - writes CLKOUT0 divide and config-load, then polls lock status with timeout
module clk_reconfig_ctrl
  import clk_gen_pkg::*;
#(
  parameter int                ADDR_W    = 11,
  parameter logic [ADDR_W-1:0] DIV_ADDR  = ADDR_W'(DEF_DIV_ADDR),
  parameter logic [ADDR_W-1:0] CFG_ADDR  = ADDR_W'(DEF_CFG_ADDR),
  parameter logic [31:0]       CFG_LOAD  = DEF_CFG_LOAD,
  parameter logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(DEF_STAT_ADDR),
  parameter int                POLL_GAP  = 16,
  parameter int                TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [7:0]           req_div,
  output logic                 done,
  output logic                 err,
  output logic                 busy,
  clk_reconfig_ctrl_if.master  m_axi
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  state_t         state, state_n;
  step_t          step;
  logic [7:0]     div_q;
  logic           aw_done, w_done;
  logic           err_q, fin_err;
  logic [TW-1:0]  tmo_cnt;
  logic [GW-1:0]  gap_cnt;
  logic           aw_hs, w_hs, tmo, poll_phase;
  logic           unused_rdata;

  assign aw_hs        = (state == WR) && !aw_done && m_axi.awready;
  assign w_hs         = (state == WR) && !w_done && m_axi.wready;
  assign tmo          = (tmo_cnt == TMO_MAX);
  assign poll_phase   = (state == RD) || (state == RD_RESP) || (state == GAP);
  assign unused_rdata = ^m_axi.rdata[31:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    fin_err = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_div == 8'd0) begin
            state_n = FIN;
            fin_err = 1'b1;
          end else begin
            state_n = WR;
          end
        end
      end
      WR: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = WR_RESP;
      end
      WR_RESP: begin
        if (m_axi.bvalid) begin
          if (m_axi.bresp != RESP_OKAY) begin
            state_n = FIN;
            fin_err = 1'b1;
          end else if (step == DIV) begin
            state_n = WR;
          end else begin
            state_n = RD;
          end
        end
      end
      RD: begin
        // A granted address always wins over a timeout expiring in the same cycle
        if (m_axi.arready) begin
          state_n = RD_RESP;
        end else if (tmo) begin
          state_n = FIN;
          fin_err = 1'b1;
        end
      end
      RD_RESP: begin
        if (m_axi.rvalid) begin
          if (m_axi.rresp != RESP_OKAY) begin
            state_n = FIN;
            fin_err = 1'b1;
          end else if (m_axi.rdata[0]) begin
            state_n = FIN;
          end else begin
            state_n = GAP;
          end
        end
      end
      GAP: begin
        if (tmo) begin
          state_n = FIN;
          fin_err = 1'b1;
        end else if (gap_cnt == GAP_LAST) begin
          state_n = RD;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step    <= DIV;
      div_q   <= 8'd0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err_q   <= 1'b0;
      tmo_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        div_q <= req_div;
        step  <= DIV;
      end
      if (state == WR_RESP && m_axi.bvalid && m_axi.bresp == RESP_OKAY) step <= CFG;
      // Completion flags live only for the current WR visit
      aw_done <= (state == WR && state_n == WR) ? (aw_done || aw_hs) : 1'b0;
      w_done  <= (state == WR && state_n == WR) ? (w_done || w_hs) : 1'b0;
      if (state_n == FIN) err_q <= fin_err;
      if (poll_phase) begin
        if (!tmo) tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    req_ready     = (state == IDLE);
    busy          = (state != IDLE);
    done          = (state == FIN);
    err           = (state == FIN) && err_q;
    m_axi.awvalid = (state == WR) && !aw_done;
    m_axi.wvalid  = (state == WR) && !w_done;
    m_axi.awaddr  = '0;
    m_axi.wdata   = 32'd0;
    if (state == WR) begin
      m_axi.awaddr = (step == DIV) ? DIV_ADDR : CFG_ADDR;
      m_axi.wdata  = (step == DIV) ? {24'd0, div_q} : CFG_LOAD;
    end
    m_axi.wstrb   = 4'hF;
    m_axi.bready  = (state == WR_RESP);
    m_axi.arvalid = (state == RD);
    m_axi.araddr  = (state == RD) ? STAT_ADDR : '0;
    m_axi.rready  = (state == RD_RESP);
  end

endmodule

// File: tb/tb_clk_reconfig_ctrl.sv
// tb/tb_clk_reconfig_ctrl.sv - directed bench for clk_reconfig_ctrl with a configurable AXI-Lite slave
module tb_clk_reconfig_ctrl;
  import clk_gen_pkg::*;

  localparam int PG  = 16;
  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, done, err, busy;
  logic [7:0] req_div;

  always #5 clk = ~clk;

  clk_reconfig_ctrl_if #(.ADDR_W(11)) axi ();

  clk_reconfig_ctrl #(.ADDR_W(11), .POLL_GAP(PG), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_div(req_div), .done(done), .err(err), .busy(busy), .m_axi(axi)
  );

  int vecs = 0;
  int errs = 0;

  int aw_delay, w_delay, bresp_err_idx, lock_after;
  int aw_wait, w_wait;
  int n_aw, n_w, n_b, n_ar, n_r, cyc;
  int bready_early, bad_strb, any_valid;
  logic [10:0] aw_log [8];
  logic [31:0] w_log  [8];
  logic [10:0] ar_log [16];
  int          ar_cyc [16];

  // Bus monitor: records every completed beat
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (axi.awvalid || axi.wvalid || axi.arvalid) any_valid++;
      if (axi.bready && !(n_aw > n_b && n_w > n_b)) bready_early++;
      if (axi.awvalid && axi.awready) begin
        if (n_aw < 8) aw_log[n_aw] = axi.awaddr;
        n_aw++;
      end
      if (axi.wvalid && axi.wready) begin
        if (n_w < 8) w_log[n_w] = axi.wdata;
        if (axi.wstrb !== 4'hF) bad_strb++;
        n_w++;
      end
      if (axi.bvalid && axi.bready) n_b++;
      if (axi.arvalid && axi.arready) begin
        if (n_ar < 16) begin
          ar_log[n_ar] = axi.araddr;
          ar_cyc[n_ar] = cyc;
        end
        n_ar++;
      end
      if (axi.rvalid && axi.rready) n_r++;
    end
  end

  // Slave driver, updated away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = RESP_OKAY;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rresp = RESP_OKAY; axi.rdata = 32'd0;
      aw_wait = 0; w_wait = 0;
    end else begin
      if (axi.awvalid) begin
        if (aw_wait >= aw_delay) axi.awready = 1'b1;
        else begin axi.awready = 1'b0; aw_wait++; end
      end else begin
        axi.awready = 1'b0; aw_wait = 0;
      end
      if (axi.wvalid) begin
        if (w_wait >= w_delay) axi.wready = 1'b1;
        else begin axi.wready = 1'b0; w_wait++; end
      end else begin
        axi.wready = 1'b0; w_wait = 0;
      end
      axi.bvalid  = (n_aw > n_b) && (n_w > n_b);
      axi.bresp   = (n_b == bresp_err_idx) ? RESP_SLVERR : RESP_OKAY;
      axi.arready = 1'b1;
      axi.rvalid  = (n_ar > n_r);
      axi.rresp   = RESP_OKAY;
      axi.rdata   = (n_r >= lock_after) ? 32'h0000_0001 : 32'hFFFF_FFFE;
    end
  end

  task automatic clear_log();
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
    bready_early = 0; bad_strb = 0; any_valid = 0;
    aw_delay = 0; w_delay = 0; bresp_err_idx = -1; lock_after = 0;
  endtask

  task automatic send_req(input logic [7:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_div   = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit seen, output logic e, output int at_cyc);
    seen = 1'b0; e = 1'b0; at_cyc = 0;
    for (int i = 0; i < max && !seen; i++) begin
      if (done) begin
        seen = 1'b1; e = err; at_cyc = cyc;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", busy); end
    vecs++; if ({done, err} !== 2'b00) begin errs++; $display("FAIL rst_done_err got %b want 00", {done, err}); end
    vecs++; if ({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready} !== 5'b0) begin
      errs++; $display("FAIL rst_valids got %b want 00000", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}); end
    vecs++; if ({axi.awaddr, axi.araddr, axi.wdata} !== 54'd0) begin
      errs++; $display("FAIL rst_addr_data got %h/%h/%h want 0", axi.awaddr, axi.araddr, axi.wdata); end
  endtask

  task automatic test_nominal();
    bit seen; logic e; int t;
    clear_log();
    send_req(8'd10);
    vecs++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errs++; $display("FAIL nom_busy got busy=%b rdy=%b want 1/0", busy, req_ready); end
    wait_done(200, seen, e, t);
    vecs++; if (!seen || e !== 1'b0) begin errs++; $display("FAIL nom_done got seen=%b err=%b want 1/0", seen, e); end
    vecs++; if (n_aw !== 2 || n_w !== 2) begin errs++; $display("FAIL nom_wr_count got aw=%0d w=%0d want 2/2", n_aw, n_w); end
    vecs++; if (aw_log[0] !== 11'h208 || w_log[0] !== 32'h0A) begin
      errs++; $display("FAIL nom_div_wr got %h/%h want 208/0000000a", aw_log[0], w_log[0]); end
    vecs++; if (aw_log[1] !== 11'h25C || w_log[1] !== 32'h3) begin
      errs++; $display("FAIL nom_cfg_wr got %h/%h want 25c/00000003", aw_log[1], w_log[1]); end
    vecs++; if (n_ar !== 1 || ar_log[0] !== 11'h004) begin
      errs++; $display("FAIL nom_rd got n=%0d addr=%h want 1/004", n_ar, ar_log[0]); end
    vecs++; if (bad_strb !== 0) begin errs++; $display("FAIL nom_wstrb got %0d bad beats want 0", bad_strb); end
    @(negedge clk);
    vecs++; if (done !== 1'b0 || req_ready !== 1'b1) begin errs++; $display("FAIL nom_pulse got done=%b rdy=%b want 0/1", done, req_ready); end
  endtask

  task automatic test_slow_lock();
    bit seen; logic e; int t;
    clear_log();
    lock_after = 3;
    send_req(8'd4);
    wait_done(300, seen, e, t);
    vecs++; if (!seen || e !== 1'b0) begin errs++; $display("FAIL slow_done got seen=%b err=%b want 1/0", seen, e); end
    vecs++; if (n_ar !== 4) begin errs++; $display("FAIL slow_ar_count got %0d want 4", n_ar); end
    for (int i = 1; i < 4; i++) begin
      vecs++; if (ar_cyc[i] - ar_cyc[i-1] < PG + 1) begin
        errs++; $display("FAIL slow_gap%0d got %0d cycles want >=%0d", i, ar_cyc[i] - ar_cyc[i-1], PG + 1); end
    end
  endtask

  task automatic test_split_write(input int awd, input int wd);
    bit seen; logic e; int t;
    clear_log();
    aw_delay = awd; w_delay = wd;
    send_req(8'd7);
    wait_done(300, seen, e, t);
    vecs++; if (!seen || e !== 1'b0) begin errs++; $display("FAIL split_done aw%0d_w%0d got seen=%b err=%b want 1/0", awd, wd, seen, e); end
    vecs++; if (bready_early !== 0) begin errs++; $display("FAIL split_bready aw%0d_w%0d got %0d early want 0", awd, wd, bready_early); end
    vecs++; if (n_aw !== 2 || n_w !== 2 || w_log[0] !== 32'h7) begin
      errs++; $display("FAIL split_beats got aw=%0d w=%0d d=%h want 2/2/7", n_aw, n_w, w_log[0]); end
  endtask

  task automatic test_bad_resp();
    bit seen; logic e; int t;
    clear_log();
    bresp_err_idx = 0;
    send_req(8'd12);
    wait_done(100, seen, e, t);
    vecs++; if (!seen || e !== 1'b1) begin errs++; $display("FAIL bad_done got seen=%b err=%b want 1/1", seen, e); end
    vecs++; if (n_aw !== 1 || n_ar !== 0) begin errs++; $display("FAIL bad_traffic got aw=%0d ar=%0d want 1/0", n_aw, n_ar); end
    @(negedge clk);
    vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL bad_ready got %b want 1", req_ready); end
  endtask

  task automatic test_timeout();
    bit seen; logic e; int t;
    clear_log();
    lock_after = 1000;
    send_req(8'd3);
    wait_done(400, seen, e, t);
    vecs++; if (!seen || e !== 1'b1) begin errs++; $display("FAIL tmo_done got seen=%b err=%b want 1/1", seen, e); end
    vecs++; if (t - ar_cyc[0] < TMO || t - ar_cyc[0] > TMO + PG + 4) begin
      errs++; $display("FAIL tmo_latency got %0d want %0d..%0d", t - ar_cyc[0], TMO, TMO + PG + 4); end
    vecs++; if (n_r !== n_ar) begin errs++; $display("FAIL tmo_orphan got r=%0d ar=%0d want equal", n_r, n_ar); end
  endtask

  task automatic test_zero_div();
    bit seen; logic e; int t;
    clear_log();
    send_req(8'd0);
    wait_done(2, seen, e, t);
    vecs++; if (!seen || e !== 1'b1) begin errs++; $display("FAIL zero_done got seen=%b err=%b want 1/1", seen, e); end
    @(negedge clk);
    vecs++; if (any_valid !== 0) begin errs++; $display("FAIL zero_traffic got %0d valid cycles want 0", any_valid); end
  endtask

  task automatic test_reset_midop();
    bit seen, got_aw; logic e; int t;
    clear_log();
    aw_delay = 50;
    send_req(8'h22);
    got_aw = 1'b0;
    for (int i = 0; i < 10 && !got_aw; i++) begin
      if (axi.awvalid) got_aw = 1'b1; else @(negedge clk);
    end
    vecs++; if (!got_aw) begin errs++; $display("FAIL midop_aw got awvalid=%b want 1", axi.awvalid); end
    rst = 1'b1;
    #1;
    vecs++; if ({axi.awvalid, axi.wvalid, axi.arvalid} !== 3'b000 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errs++; $display("FAIL midop_rst got valids=%b busy=%b rdy=%b want 000/0/1",
                       {axi.awvalid, axi.wvalid, axi.arvalid}, busy, req_ready); end
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    send_req(8'h05);
    wait_done(200, seen, e, t);
    vecs++; if (!seen || e !== 1'b0 || w_log[0] !== 32'h5) begin
      errs++; $display("FAIL midop_retry got seen=%b err=%b d=%h want 1/0/5", seen, e, w_log[0]); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_div = 8'd0; cyc = 0;
    clear_log();
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_slow_lock();
    test_split_write(0, 5);
    test_split_write(5, 0);
    test_bad_resp();
    test_timeout();
    test_zero_div();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
